// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter with IDLE/RUN/DONE control and terminal-count pulse
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic [WIDTH-1:0] count_n;
    logic             tc_n, busy_n, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            tc     <= tc_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        tc_n     = 1'b0;
        busy_n   = busy;
        done_n   = done;

        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            state_n  = IDLE;
            busy_n   = 1'b0;
            done_n   = 1'b0;
        end else if (en) begin
            // en low freezes everything except load, so start is gated too
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        count_n = reload;
                        state_n = RUN;
                        busy_n  = 1'b1;
                        done_n  = 1'b0;
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        count_n = count - WIDTH'(1);
                    end else begin
                        tc_n = 1'b1;
                        if (auto_reload) begin
                            count_n = reload;
                        end else begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - directed self-checking bench for down_counter_timer
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int pulses;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int c, input int t, input int b, input int d);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".tc"},    32'(tc),    32'(t));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic do_load(input int v);
        load_val = W'(v);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; auto_reload = 1'b0;
        tick(); tick();
        check_state("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_state("post_reset", 0, 0, 0, 0);

        // one-shot from 3
        do_load(3);
        check_state("os_load", 3, 0, 0, 0);
        do_start();
        check_state("os_start", 3, 0, 1, 0);
        tick(); check_state("os_e1", 2, 0, 1, 0);
        tick(); check_state("os_e2", 1, 0, 1, 0);
        tick(); check_state("os_e3", 0, 0, 1, 0);
        tick(); check_state("os_e4", 0, 1, 0, 1);
        tick(); check_state("os_hold", 0, 0, 0, 1);
        tick(); check_state("os_hold2", 0, 0, 0, 1);

        // restart from DONE reloads last value
        do_start();
        check_state("restart", 3, 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(); check_state("restart_run", 3 - k, 0, 1, 0);
        end
        tick(); check_state("restart_tc", 0, 1, 0, 1);

        // enable gating
        do_load(2);
        do_start();
        en = 1'b1; tick(); check_state("en_1", 1, 0, 1, 0);
        en = 1'b0; tick(); check_state("en_0a", 1, 0, 1, 0);
        en = 1'b0; tick(); check_state("en_0b", 1, 0, 1, 0);
        en = 1'b1; tick(); check_state("en_1b", 0, 0, 1, 0);
        en = 1'b1; tick(); check_state("en_1c", 0, 1, 0, 1);

        // auto-reload period 3
        do_load(2);
        auto_reload = 1'b1;
        do_start();
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (tc) pulses++;
            check_state("ar", (k % 3 == 1) ? 1 : (k % 3 == 2) ? 0 : 2, (k % 3 == 0) ? 1 : 0, 1, 0);
        end
        check("ar_pulses", 32'(pulses), 32'd4);
        auto_reload = 1'b0;
        tick(); tick(); tick();
        check_state("ar_off_done", 0, 1, 0, 1);

        // reload 0 with auto-reload: tc every enabled cycle
        do_load(0);
        auto_reload = 1'b1;
        do_start();
        for (int k = 0; k < 3; k++) begin
            tick(); check_state("ar0", 0, 1, 1, 0);
        end
        auto_reload = 1'b0;

        // load and start together: load wins
        load_val = W'(7);
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check_state("prio", 7, 0, 0, 0);
        tick(); check_state("prio_hold", 7, 0, 0, 0);

        // max value, no underflow
        do_load(15);
        do_start();
        for (int k = 1; k <= 15; k++) begin
            tick(); check_state("max", 15 - k, 0, 1, 0);
        end
        tick(); check_state("max_tc", 0, 1, 0, 1);
        tick(); check_state("max_hold", 0, 0, 0, 1);

        // load 0 one-shot
        do_load(0);
        do_start();
        tick(); check_state("zero_tc", 0, 1, 0, 1);

        // asynchronous reset mid-count
        do_load(8);
        do_start();
        tick(); tick(); tick();
        check_state("pre_rst", 5, 0, 1, 0);
        #2 rst = 1'b1;
        #1 check_state("async_rst", 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick(); check_state("rst_idle", 0, 0, 0, 0);
        tick(); check_state("rst_idle2", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
